// File: rtl/seg7_if.sv
// seg7_if: write port and display outputs of the 4-digit seven-segment scanner
interface seg7_if;
  logic        WE;
  logic [15:0] WDATA;
  logic [3:0]  DP_IN;
  logic [7:0]  nSEG;
  logic [3:0]  nAN;
  logic        FRAME;
  modport master (output WE, WDATA, DP_IN, input nSEG, nAN, FRAME);
  modport slave  (input WE, WDATA, DP_IN, output nSEG, nAN, FRAME);
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 4-digit hex display driver with frame-synchronous double buffer
module seg7_scan #(
  parameter int SCAN_DIV  = 12500,
  parameter int BLANK_CYC = 500,
  parameter bit LZB       = 1'b0
) (
  input logic   CLK,
  input logic   RST,
  seg7_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   shd_dat_q, shd_dat_d, act_dat_q, act_dat_d;
  logic [3:0]    shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
  logic          pending_q, pending_d;
  logic [7:0]    nseg_q, nseg_d;
  logic [3:0]    nan_q, nan_d;
  logic          frame_q, frame_d;
  logic          wrap, boundary, blank;
  logic [3:0]    hex;
  logic [6:0]    seg;
  always_comb begin
    wrap      = div_cnt_q == CW'(SCAN_DIV - 1);
    boundary  = wrap && dig_q == 2'd3;
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    dig_d     = wrap ? dig_q + 2'd1 : dig_q;
    shd_dat_d = bus.WE ? bus.WDATA : shd_dat_q;
    shd_dp_d  = bus.WE ? bus.DP_IN : shd_dp_q;
    // commit uses the pre-write shadow; a write on the boundary stays pending
    act_dat_d = boundary && pending_q ? shd_dat_q : act_dat_q;
    act_dp_d  = boundary && pending_q ? shd_dp_q : act_dp_q;
    pending_d = bus.WE | (pending_q & ~boundary);
    frame_d   = boundary;
  end
  always_comb begin
    hex   = act_dat_q[{dig_q, 2'b00} +: 4];
    blank = LZB && (dig_q == 2'd3 ? act_dat_q[15:12] == 4'h0 :
                    dig_q == 2'd2 ? act_dat_q[15:8] == 8'h00 :
                    dig_q == 2'd1 ? act_dat_q[15:4] == 12'h000 : 1'b0);
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    nseg_d = {~act_dp_q[dig_q], blank ? 7'h7F : seg};
    nan_d  = div_cnt_q < CW'(BLANK_CYC) ? 4'hF : ~(4'b0001 << dig_q);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt_q <= '0;
      dig_q     <= '0;
      shd_dat_q <= '0;
      shd_dp_q  <= '0;
      act_dat_q <= '0;
      act_dp_q  <= '0;
      pending_q <= 1'b0;
      nseg_q    <= 8'hFF;
      nan_q     <= 4'hF;
      frame_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_q     <= dig_d;
      shd_dat_q <= shd_dat_d;
      shd_dp_q  <= shd_dp_d;
      act_dat_q <= act_dat_d;
      act_dp_q  <= act_dp_d;
      pending_q <= pending_d;
      nseg_q    <= nseg_d;
      nan_q     <= nan_d;
      frame_q   <= frame_d;
    end
  end
  assign bus.nSEG  = nseg_q;
  assign bus.nAN   = nan_q;
  assign bus.FRAME = frame_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed checks of scanning, double buffering, blanking and reset (SCAN_DIV=8, BLANK_CYC=2)
module tb_seg7_scan;
  logic        clk = 1'b0, rst = 1'b1, we = 1'b0;
  logic [15:0] wdata = '0;
  logic [3:0]  dp = '0;
  int          k, vectors, miscompares;
  logic [7:0]  c0[4], n0[4], c1[4], n1[4];
  always #5 clk = ~clk;
  seg7_if b0();
  seg7_if b1();
  assign b0.WE = we;
  assign b0.WDATA = wdata;
  assign b0.DP_IN = dp;
  assign b1.WE = we;
  assign b1.WDATA = wdata;
  assign b1.DP_IN = dp;
  seg7_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .LZB(1'b0)) u0 (.CLK(clk), .RST(rst), .bus(b0.slave));
  seg7_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .LZB(1'b1)) u1 (.CLK(clk), .RST(rst), .bus(b1.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at k=%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask
  task automatic step();
    logic [2:0] d;
    logic [1:0] g;
    logic [3:0] an;
    logic       fr;
    @(posedge clk);
    #1;
    k++;
    if (k > 1 && (k - 1) % 32 == 0) begin
      c0 = n0;
      c1 = n1;
    end
    d  = 3'((k - 1) % 8);
    g  = 2'(((k - 1) / 8) % 4);
    an = d < 3'd2 ? 4'hF : ~(4'b0001 << g);
    fr = k % 32 == 0;
    chk("nAN", 32'(b0.nAN), 32'(an));
    chk("nAN_lzb", 32'(b1.nAN), 32'(an));
    chk("FRAME", 32'(b0.FRAME), 32'(fr));
    chk("nSEG", 32'(b0.nSEG), 32'(c0[g]));
    chk("nSEG_lzb", 32'(b1.nSEG), 32'(c1[g]));
  endtask
  task automatic wr(input logic [15:0] data, input logic [3:0] dpv);
    we = 1'b1;
    wdata = data;
    dp = dpv;
    step();
    we = 1'b0;
  endtask
  task automatic run_to(input int n);
    while (k < n) step();
  endtask
  initial begin
    k = 0;
    vectors = 0;
    miscompares = 0;
    c0 = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
    n0 = c0;
    c1 = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
    n1 = c1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_nAN", 32'(b0.nAN), 32'h0000000F);
    chk("rst_nSEG", 32'(b0.nSEG), 32'h000000FF);
    chk("rst_FRAME", 32'(b0.FRAME), 32'h00000000);
    chk("rst_nSEG_lzb", 32'(b1.nSEG), 32'h000000FF);
    rst = 1'b0;
    run_to(10);
    wr(16'h12AF, 4'b0100);
    n0 = '{8'h8E, 8'h88, 8'h24, 8'hF9};
    n1 = n0;
    run_to(40);
    wr(16'h1111, 4'b0000);
    run_to(50);
    wr(16'h2222, 4'b0000);
    n0 = '{8'hA4, 8'hA4, 8'hA4, 8'hA4};
    n1 = n0;
    run_to(70);
    wr(16'h1111, 4'b0000);
    n0 = '{8'hF9, 8'hF9, 8'hF9, 8'hF9};
    n1 = n0;
    run_to(95);
    wr(16'h3333, 4'b0000);
    run_to(97);
    n0 = '{8'hB0, 8'hB0, 8'hB0, 8'hB0};
    n1 = n0;
    run_to(140);
    wr(16'h0040, 4'b1000);
    n0 = '{8'hC0, 8'h99, 8'hC0, 8'h40};
    n1 = '{8'hC0, 8'h99, 8'hFF, 8'h7F};
    run_to(170);
    wr(16'h0000, 4'b0000);
    n0 = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
    n1 = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
    run_to(200);
    wr(16'h5555, 4'b0000);
    run_to(203);
    rst = 1'b1;
    #1;
    chk("arst_nAN", 32'(b0.nAN), 32'h0000000F);
    chk("arst_nSEG", 32'(b0.nSEG), 32'h000000FF);
    chk("arst_FRAME", 32'(b0.FRAME), 32'h00000000);
    chk("arst_nSEG_lzb", 32'(b1.nSEG), 32'h000000FF);
    we = 1'b1;
    wdata = 16'h7777;
    dp = 4'hF;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    we = 1'b0;
    rst = 1'b0;
    k = 0;
    run_to(64);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter SCAN_DIV, default 12500, CLK cycles per digit slot (50 MHz -> 4 kHz digit rate, 1 kHz frame); legal range 4..65535.
REQ-002 Parameter BLANK_CYC, default 500, CLK cycles at the start of each slot with all anodes off (anti-ghosting); legal range 1..SCAN_DIV-2.
REQ-003 Parameter LZB, default 0, 1 = leading-zero blanking enabled.
REQ-004 CLK  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 RST  input  1  reset, asynchronous and active-high.
REQ-006 WE  input  1  write strobe, one-cycle pulse from the MicroBlaze MCS GPO decode.
REQ-007 WDATA  input  16  four hex digits, [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-008 DP_IN  input  4  decimal point per digit, 1 = lit, bit n -> digit n.
REQ-009 nSEG  output  8  active-low segments, [6:0] = g..a, [7] = dp; registered.
REQ-010 nAN  output  4  active-low anodes, bit n -> digit n; registered.
REQ-011 FRAME  output  1  one-cycle pulse at each frame boundary (commit point).

Function
REQ-012 Slot counter div_cnt SHALL count 0..SCAN_DIV-1, then wrap to 0; digit index dig (2 bits) SHALL increment when div_cnt wraps, 3 -> 0 wrap-around.
REQ-013 Frame boundary SHALL be the CLK edge where div_cnt wraps and dig goes 3 -> 0; FRAME SHALL be high the cycle after that edge, for exactly one cycle.
REQ-014 Double buffer: WE=1 SHALL load shadow <= {WDATA, DP_IN} and set pending=1 on the same edge; WE with pending already 1 overwrites shadow (last write wins).
REQ-015 At a frame boundary with pending=1, active <= shadow and pending <= 0; with pending=0, active unchanged.
REQ-016 WE coinciding with a frame boundary: active takes the pre-write shadow, shadow takes new data, pending stays 1 (new data commits next frame).
REQ-017 Display never shows a mix of two writes within one frame.
REQ-018 While div_cnt < BLANK_CYC: nAN = 4'hF; otherwise nAN = ~(4'b0001 << dig).
REQ-019 nSEG[6:0] SHALL be the active-low hex decode of active digit dig: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (g..a).
REQ-020 nSEG[7] SHALL be ~DP of active digit dig.
REQ-021 LZB=1: digit n (n=3..1) blanked (nSEG[6:0]=7'h7F) when it and all higher digits are 0; digit 0 never blanked; dp unaffected by blanking.
REQ-022 Output latency: nSEG/nAN SHALL reflect dig/div_cnt/active with exactly one CLK of register delay, both updating on the same edge.
REQ-023 No combinational path from any input to any output.

Reset
REQ-024 RST=1 SHALL immediately force nAN=4'hF, nSEG=8'hFF, FRAME=0, div_cnt=0, dig=0, active=0, shadow=0, pending=0.
REQ-025 RST asserted mid-slot or with pending=1 SHALL discard pending data; after release scanning restarts at digit 0 with blanking interval first.
REQ-026 WE during RST SHALL be ignored.

Verification (SCAN_DIV=8, BLANK_CYC=2 unless noted)
REQ-027 Reset release, no writes -> nAN cycles 1111,1111,1110x6, then 1111x2,1101x6 ... ; nSEG=8'hC0 on every lit slot; FRAME pulses every 32 cycles.
REQ-028 WE with WDATA=16'h12AF, DP_IN=4'b0100 mid-frame -> display unchanged until next FRAME; following frame digit0 nSEG=8'h8E, digit1 8'h88, digit2 8'h24 (dp lit), digit3 8'hF9.
REQ-029 Two writes 16'h1111 then 16'h2222 in one frame -> next frame shows only 2222; no 1 ever displayed.
REQ-030 WE on the frame-boundary edge with 16'h3333 while shadow=16'h1111 pending -> this frame shows 1111, the next shows 3333.
REQ-031 LZB=1, WDATA=16'h0040 -> digits 3 and 2 nSEG[6:0]=7'h7F, digit1 7'h19, digit0 7'h40; WDATA=16'h0000 -> only digit0 lit showing 0.
REQ-032 RST pulse mid-slot with pending write -> outputs at reset values within the same cycle; after release display shows 0000, pending write lost.
